// File: rtl/store_queue.sv
// store_queue: in-order store queue with store-to-load forwarding.
//   Stores are dispatched at the tail, executed out of order by index,
//   committed in order from cmt, and drained in order from the head to the
//   D-cache write port.
// Ports:
//   clock, reset                 clock; synchronous active-high reset
//   disp_en / sq_tail            allocate at tail / current tail pointer
//   sq_full, sq_empty            occupancy flags from registered pointers
//   exe_en, exe_idx, exe_addr,
//   exe_data, exe_bytes          executed store payload (lane-aligned data)
//   commit_en                    retire oldest uncommitted store
//   squash                       drop every uncommitted entry
//   ld_addr, ld_tail             load lookup address and age tag
//   ld_stall, ld_bytes, ld_data  combinational forwarding result
//   mem_wr_*                     D-cache write port, mem_wr_ready handshake
//   commit_err                   sticky: commit found a non-executed entry
module store_queue #(
  parameter int unsigned SQ_DEPTH = 8,
  localparam int unsigned IDX_W = $clog2(SQ_DEPTH),
  localparam int unsigned PTR_W = IDX_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             disp_en,
  output logic [PTR_W-1:0] sq_tail,
  output logic             sq_full,
  output logic             sq_empty,
  input  logic             exe_en,
  input  logic [IDX_W-1:0] exe_idx,
  input  logic [31:0]      exe_addr,
  input  logic [31:0]      exe_data,
  input  logic [3:0]       exe_bytes,
  input  logic             commit_en,
  input  logic             squash,
  input  logic [31:0]      ld_addr,
  input  logic [PTR_W-1:0] ld_tail,
  output logic             ld_stall,
  output logic [3:0]       ld_bytes,
  output logic [31:0]      ld_data,
  output logic             mem_wr_en,
  output logic [31:0]      mem_wr_addr,
  output logic [31:0]      mem_wr_data,
  output logic [3:0]       mem_wr_bytes,
  input  logic             mem_wr_ready,
  output logic             commit_err
);

  typedef enum logic [1:0] {
    ENT_EMPTY,
    ENT_ALLOC,
    ENT_EXEC,
    ENT_COMMIT
  } ent_state_t;

  ent_state_t       state_q [SQ_DEPTH];
  logic [31:0]      addr_q  [SQ_DEPTH];
  logic [31:0]      data_q  [SQ_DEPTH];
  logic [3:0]       bytes_q [SQ_DEPTH];

  logic [PTR_W-1:0] head_q, cmt_q, tail_q;
  logic             err_q;

  logic [IDX_W-1:0] head_idx, cmt_idx, tail_idx;
  logic [PTR_W-1:0] count;
  logic             do_disp, do_exe, do_commit, commit_bad, do_drain;

  assign head_idx = head_q[IDX_W-1:0];
  assign cmt_idx  = cmt_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];

  assign count    = tail_q - head_q;
  assign sq_full  = (count == PTR_W'(SQ_DEPTH));
  assign sq_empty = (count == '0);
  assign sq_tail  = tail_q;

  assign mem_wr_en    = (state_q[head_idx] == ENT_COMMIT);
  assign mem_wr_addr  = addr_q[head_idx];
  assign mem_wr_data  = data_q[head_idx];
  assign mem_wr_bytes = bytes_q[head_idx];
  assign commit_err   = err_q;

  // Each action qualifies on a distinct entry state, so no two of them can
  // target the same entry in one cycle and they can all be applied together.
  assign do_disp    = disp_en && !sq_full && !squash;
  assign do_exe     = exe_en && !squash && (state_q[exe_idx] == ENT_ALLOC);
  assign do_commit  = commit_en && !squash && (state_q[cmt_idx] == ENT_EXEC);
  assign commit_bad = commit_en && !squash && (state_q[cmt_idx] != ENT_EXEC);
  assign do_drain   = mem_wr_en && mem_wr_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
      err_q  <= 1'b0;
      for (int unsigned i = 0; i < SQ_DEPTH; i++) state_q[i] <= ENT_EMPTY;
    end else begin
      if (squash) begin
        for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
          if (state_q[i] == ENT_ALLOC || state_q[i] == ENT_EXEC)
            state_q[i] <= ENT_EMPTY;
        end
        tail_q <= cmt_q;
      end else begin
        if (do_disp) begin
          state_q[tail_idx] <= ENT_ALLOC;
          tail_q            <= tail_q + 1'b1;
        end
        if (do_exe) state_q[exe_idx] <= ENT_EXEC;
        if (do_commit) begin
          state_q[cmt_idx] <= ENT_COMMIT;
          cmt_q            <= cmt_q + 1'b1;
        end
      end
      if (do_drain) begin
        state_q[head_idx] <= ENT_EMPTY;
        head_q            <= head_q + 1'b1;
      end
      if (commit_bad) err_q <= 1'b1;
    end
  end

  // Payload is only meaningful once an entry is executed, so it needs no reset.
  always_ff @(posedge clock) begin
    if (do_exe) begin
      addr_q[exe_idx]  <= exe_addr;
      data_q[exe_idx]  <= exe_data;
      bytes_q[exe_idx] <= exe_bytes;
    end
  end

  // Walk oldest to youngest across the load's range; later matches overwrite
  // earlier ones so each lane ends up with the youngest older store.
  logic [PTR_W-1:0] ld_len;
  logic             fwd_stall;
  logic [3:0]       fwd_bytes;
  logic [31:0]      fwd_data;
  logic [IDX_W-1:0] ent;

  assign ld_len = ld_tail - head_q;

  always_comb begin
    fwd_stall = 1'b0;
    fwd_bytes = '0;
    fwd_data  = '0;
    ent       = '0;
    for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
      ent = head_idx + IDX_W'(i);
      if (PTR_W'(i) < ld_len) begin
        if (state_q[ent] == ENT_ALLOC) begin
          fwd_stall = 1'b1;
        end else if ((state_q[ent] == ENT_EXEC || state_q[ent] == ENT_COMMIT) &&
                     (addr_q[ent][31:2] == ld_addr[31:2])) begin
          for (int unsigned b = 0; b < 4; b++) begin
            if (bytes_q[ent][b]) begin
              fwd_bytes[b]        = 1'b1;
              fwd_data[8*b +: 8] = data_q[ent][8*b +: 8];
            end
          end
        end
      end
    end
  end

  assign ld_stall = fwd_stall;
  assign ld_bytes = fwd_stall ? '0 : fwd_bytes;
  assign ld_data  = fwd_stall ? '0 : fwd_data;

endmodule

// File: tb/tb_store_queue.sv
// tb_store_queue: directed-vector bench for store_queue.
module tb_store_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        disp_en;
  logic [3:0]  sq_tail;
  logic        sq_full, sq_empty;
  logic        exe_en;
  logic [2:0]  exe_idx;
  logic [31:0] exe_addr, exe_data;
  logic [3:0]  exe_bytes;
  logic        commit_en, squash;
  logic [31:0] ld_addr;
  logic [3:0]  ld_tail;
  logic        ld_stall;
  logic [3:0]  ld_bytes;
  logic [31:0] ld_data;
  logic        mem_wr_en;
  logic [31:0] mem_wr_addr, mem_wr_data;
  logic [3:0]  mem_wr_bytes;
  logic        mem_wr_ready;
  logic        commit_err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  store_queue #(.SQ_DEPTH(8)) dut (
    .clock(clock), .reset(reset),
    .disp_en(disp_en), .sq_tail(sq_tail), .sq_full(sq_full), .sq_empty(sq_empty),
    .exe_en(exe_en), .exe_idx(exe_idx), .exe_addr(exe_addr), .exe_data(exe_data),
    .exe_bytes(exe_bytes), .commit_en(commit_en), .squash(squash),
    .ld_addr(ld_addr), .ld_tail(ld_tail), .ld_stall(ld_stall), .ld_bytes(ld_bytes),
    .ld_data(ld_data), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_bytes(mem_wr_bytes),
    .mem_wr_ready(mem_wr_ready), .commit_err(commit_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    disp_en = 1'b0; exe_en = 1'b0; exe_idx = '0; exe_addr = '0; exe_data = '0;
    exe_bytes = '0; commit_en = 1'b0; squash = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic execute(input logic [2:0] idx, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
    exe_en = 1'b1; exe_idx = idx; exe_addr = a; exe_data = d; exe_bytes = b;
  endtask

  task automatic lookup(input logic [31:0] a, input logic [3:0] t);
    ld_addr = a; ld_tail = t;
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b1; ld_addr = '0; ld_tail = '0; mem_wr_ready = 1'b0;
    do_reset();

    // Reset state
    check("rst_full", 32'(sq_full), 32'd0);
    check("rst_empty", 32'(sq_empty), 32'd1);
    check("rst_tail", 32'(sq_tail), 32'd0);
    check("rst_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_stall", 32'(ld_stall), 32'd0);
    check("rst_bytes", 32'(ld_bytes), 32'd0);
    check("rst_data", ld_data, 32'd0);
    check("rst_err", 32'(commit_err), 32'd0);

    // Lane forwarding
    disp_en = 1'b1; tick(); disp_en = 1'b0;
    check("disp_tail", 32'(sq_tail), 32'd1);
    check("disp_empty", 32'(sq_empty), 32'd0);
    lookup(32'h100, 4'd1);
    check("alloc_stall", 32'(ld_stall), 32'd1);
    check("alloc_stall_data", ld_data, 32'd0);
    execute(3'd0, 32'h100, 32'hAABBCCDD, 4'b0011); tick(); idle();
    lookup(32'h100, 4'd1);
    check("lane_stall", 32'(ld_stall), 32'd0);
    check("lane_bytes", 32'(ld_bytes), 32'b0011);
    check("lane_data", ld_data, 32'h0000CCDD);
    lookup(32'h104, 4'd1);
    check("other_word_bytes", 32'(ld_bytes), 32'd0);
    lookup(32'h100, 4'd0);
    check("len0_bytes", 32'(ld_bytes), 32'd0);

    // Drain backpressure
    commit_en = 1'b1; tick(); commit_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_wr_en", 32'(mem_wr_en), 32'd1);
      check("bp_empty", 32'(sq_empty), 32'd0);
      tick();
    end
    check("bp_wr_addr", mem_wr_addr, 32'h100);
    check("bp_wr_data", mem_wr_data, 32'hAABBCCDD);
    check("bp_wr_bytes", 32'(mem_wr_bytes), 32'b0011);
    lookup(32'h100, 4'd1);
    check("committed_fwd", ld_data, 32'h0000CCDD);
    mem_wr_ready = 1'b1; tick();
    check("drained_wr_en", 32'(mem_wr_en), 32'd0);
    check("drained_empty", 32'(sq_empty), 32'd1);
    lookup(32'h100, 4'd1);
    check("drained_no_fwd", 32'(ld_bytes), 32'd0);

    // Youngest wins (entries 1 and 2, head = 1)
    mem_wr_ready = 1'b0;
    disp_en = 1'b1; tick(); tick(); disp_en = 1'b0;
    check("yw_tail", 32'(sq_tail), 32'd3);
    execute(3'd1, 32'h100, 32'h11111111, 4'b1111); tick();
    execute(3'd2, 32'h100, 32'h22222222, 4'b0001);
    lookup(32'h100, 4'd3);
    check("same_cycle_exe_stall", 32'(ld_stall), 32'd1);
    tick(); idle();
    lookup(32'h100, 4'd3);
    check("yw_bytes", 32'(ld_bytes), 32'hF);
    check("yw_data", ld_data, 32'h11111122);
    lookup(32'h100, 4'd2);
    check("older_only_data", ld_data, 32'h11111111);
    execute(3'd1, 32'h100, 32'h33333333, 4'b1111); tick(); idle();
    lookup(32'h100, 4'd3);
    check("exe_nonalloc_ignored", ld_data, 32'h11111122);
    mem_wr_ready = 1'b1; commit_en = 1'b1; tick();
    check("drain1_data", mem_wr_data, 32'h11111111);
    tick(); commit_en = 1'b0;
    check("drain2_data", mem_wr_data, 32'h22222222);
    check("drain2_bytes", 32'(mem_wr_bytes), 32'b0001);
    tick();
    check("yw_empty", 32'(sq_empty), 32'd1);
    check("yw_err", 32'(commit_err), 32'd0);

    // Squash: 2 committed + 3 allocated
    do_reset(); mem_wr_ready = 1'b0;
    disp_en = 1'b1; repeat (5) tick(); disp_en = 1'b0;
    execute(3'd0, 32'h200, 32'hA0A0A0A0, 4'hF); tick();
    execute(3'd1, 32'h204, 32'hB0B0B0B0, 4'hF); tick(); idle();
    commit_en = 1'b1; tick(); tick(); commit_en = 1'b0;
    squash = 1'b1; disp_en = 1'b1; commit_en = 1'b1;
    execute(3'd2, 32'h200, 32'hDEADBEEF, 4'hF);
    tick(); idle();
    check("sq_tail", 32'(sq_tail), 32'd2);
    check("sq_err_prio", 32'(commit_err), 32'd0);
    check("sq_wr_en", 32'(mem_wr_en), 32'd1);
    check("sq_wr_addr0", mem_wr_addr, 32'h200);
    lookup(32'h200, 4'd5);
    check("sq_ld_stall", 32'(ld_stall), 32'd0);
    check("sq_ld_data", ld_data, 32'hA0A0A0A0);
    mem_wr_ready = 1'b1; tick();
    check("sq_wr_addr1", mem_wr_addr, 32'h204);
    tick();
    check("sq_drained", 32'(sq_empty), 32'd1);

    // Reset mid-operation discards a committed undrained entry
    mem_wr_ready = 1'b0;
    disp_en = 1'b1; tick(); disp_en = 1'b0;
    execute(3'd2, 32'h208, 32'h1, 4'hF); tick(); idle();
    commit_en = 1'b1; tick(); commit_en = 1'b0;
    check("mid_wr_en", 32'(mem_wr_en), 32'd1);
    do_reset();
    check("mid_rst_wr_en", 32'(mem_wr_en), 32'd0);
    check("mid_rst_empty", 32'(sq_empty), 32'd1);
    check("mid_rst_tail", 32'(sq_tail), 32'd0);

    // Fill and stall
    disp_en = 1'b1; repeat (8) tick();
    check("fill_full", 32'(sq_full), 32'd1);
    check("fill_tail", 32'(sq_tail), 32'b1000);
    tick(); disp_en = 1'b0;
    check("fill_9th_ignored", 32'(sq_tail), 32'b1000);
    lookup(32'h0, 4'd8);
    check("fill_stall", 32'(ld_stall), 32'd1);
    check("fill_stall_bytes", 32'(ld_bytes), 32'd0);
    execute(3'd0, 32'h300, 32'h1, 4'hF); tick(); idle();
    commit_en = 1'b1; tick(); commit_en = 1'b0;
    disp_en = 1'b1; mem_wr_ready = 1'b1; tick(); disp_en = 1'b0;
    check("full_disp_drain_tail", 32'(sq_tail), 32'b1000);
    check("full_disp_drain_full", 32'(sq_full), 32'd0);

    // Wrap
    do_reset(); mem_wr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      disp_en = 1'b1; tick(); disp_en = 1'b0;
      execute(3'(i), 32'h500, 32'(i), 4'hF); tick(); idle();
      commit_en = 1'b1; tick(); commit_en = 1'b0;
      tick();
    end
    check("wrap_tail", 32'(sq_tail), 32'b1010);
    check("wrap_empty", 32'(sq_empty), 32'd1);
    mem_wr_ready = 1'b0;
    disp_en = 1'b1; tick(); disp_en = 1'b0;
    execute(3'd2, 32'h400, 32'h12345678, 4'b1100); tick(); idle();
    lookup(32'h400, 4'b1011);
    check("wrap_fwd_bytes", 32'(ld_bytes), 32'b1100);
    check("wrap_fwd_data", ld_data, 32'h12340000);

    // Commit error
    disp_en = 1'b1; tick(); disp_en = 1'b0;
    commit_en = 1'b1; tick(); commit_en = 1'b0;
    check("err_after_good_commit", 32'(commit_err), 32'd0);
    commit_en = 1'b1; tick(); commit_en = 1'b0;
    check("err_set", 32'(commit_err), 32'd1);
    tick(); tick();
    check("err_sticky", 32'(commit_err), 32'd1);
    check("err_tail", 32'(sq_tail), 32'b1100);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/store_queue.md
STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 Parameter SQ_DEPTH, default 8: number of store entries, power of two.
REQ-002 Pointers are 4 bits: 3-bit index plus 1 wrap bit.
REQ-003 clock  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-004 disp_en  in  1  allocate one store at tail this cycle.
REQ-005 sq_tail  out  4  current tail pointer; dispatch tags each load with it.
REQ-006 sq_full  out  1  8 entries occupied; sq_empty  out  1  0 entries occupied.
REQ-007 exe_en  in  1; exe_idx  in  3; exe_addr  in  32; exe_data  in  32; exe_bytes  in  4: executed store, data lane-aligned to the word, bytes = lane mask.
REQ-008 commit_en  in  1  ROB retires the oldest uncommitted store.
REQ-009 squash  in  1  branch-mispredict flush.
REQ-010 ld_addr  in  32  word-aligned load address; ld_tail  in  4  load's tag.
REQ-011 ld_stall  out  1; ld_bytes  out  4; ld_data  out  32: forwarding result, combinational.
REQ-012 mem_wr_en  out  1; mem_wr_addr  out  32; mem_wr_data  out  32; mem_wr_bytes  out  4; mem_wr_ready  in  1: D-cache write port.
REQ-013 commit_err  out  1  sticky protocol-violation flag.

Function
REQ-014 Per-entry state: EMPTY -> ALLOC (dispatch) -> EXECUTED (exe_en) -> COMMITTED (commit_en) -> EMPTY (written to cache).
REQ-015 Three registered pointers: head (oldest), cmt (next to commit), tail (next free); count = tail - head mod 16.
REQ-016 sq_full = (count == 8); sq_empty = (count == 0); both derived from registered pointers only.
REQ-017 disp_en with sq_full=0: entry[tail] -> ALLOC, tail+1 next cycle; disp_en with sq_full=1 ignored, even if a drain happens the same cycle.
REQ-018 exe_en: entry[exe_idx] latches addr/data/bytes, ALLOC -> EXECUTED; exe_en to a non-ALLOC entry is ignored.
REQ-019 commit_en: entry[cmt] EXECUTED -> COMMITTED, cmt+1; if entry[cmt] is not EXECUTED, no state change and commit_err set to 1 until reset.
REQ-020 mem_wr_en = 1 iff entry[head] is COMMITTED; mem_wr_addr/data/bytes = entry[head] fields.
REQ-021 mem_wr_en && mem_wr_ready: entry[head] -> EMPTY, head+1 next cycle; one drain per cycle maximum.
REQ-022 Dispatch, execute, commit and drain in the same cycle all take effect independently.
REQ-023 Load range = entries from head up to ld_tail-1 (mod 8), length ld_tail - head mod 16; length 0 means no older stores.
REQ-024 ld_stall = 1 if any in-range entry is ALLOC; then ld_bytes = 0, ld_data = 0.
REQ-025 Otherwise, per byte lane b: the youngest in-range entry with addr[31:2] == ld_addr[31:2] and bytes[b] = 1 supplies ld_data lane b and sets ld_bytes[b].
REQ-026 Lanes with no match: ld_bytes[b] = 0, ld_data lane = 0.
REQ-027 In-range COMMITTED entries still forward until drained.
REQ-028 Same-cycle exe_en to an in-range entry is not visible to lookup until the next cycle.
REQ-029 squash: all ALLOC/EXECUTED entries -> EMPTY, tail <= cmt; COMMITTED entries, head and draining are unaffected.
REQ-030 squash has priority over disp_en/exe_en/commit_en in the same cycle.
REQ-031 Pointer wrap: index wraps 7 -> 0 and toggles the wrap bit; full/empty are distinguished only by the wrap bit.

Reset
REQ-032 On reset: head = cmt = tail = 0, all entries EMPTY, commit_err = 0.
REQ-033 After reset, outputs are: sq_full = 0, sq_empty = 1, sq_tail = 0, mem_wr_en = 0.
REQ-034 After reset, lookup outputs are: ld_stall = 0, ld_bytes = 0, ld_data = 0.
REQ-035 Reset mid-operation discards all entries, including COMMITTED undrained ones.

Verification
REQ-036 Forwarding lanes: dispatch 1 store, execute addr 0x100 data 0xAABBCCDD bytes 4'b0011, lookup ld_addr 0x100 ld_tail 1 -> stall 0, bytes 4'b0011, data 0x0000CCDD.
REQ-037 Youngest wins: two stores to 0x100 (older 0x11111111/1111, younger 0x22222222/0001), ld_tail 2 -> bytes 4'b1111, data 0x11111122.
REQ-038 Stall and fill: 8 dispatches -> sq_full = 1, 9th ignored; lookup with ld_tail 8 while any entry is ALLOC -> ld_stall = 1.
REQ-039 Drain backpressure: commit entry 0 with mem_wr_ready = 0 for 3 cycles -> mem_wr_en held and head stays 0; ready = 1 -> head = 1 next cycle.
REQ-040 Squash: 2 committed + 3 allocated, squash -> tail = 2, sq_tail = 2, committed entries still drain in order.
REQ-041 Wrap and error: 10 dispatch/commit/drain cycles -> pointers wrap correctly (sq_tail = 4'b1010); commit_en with entry[cmt] ALLOC -> commit_err = 1 and stays 1.
